// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: NREGS x DATA_W register file with a single internal read port.
// Reads Rn then Rm over two cycles and holds A/B/shift until the shifter/ALU takes them.
module operand_fetch_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rn,
  input  logic [ADDR_W-1:0] req_rm,
  input  logic [1:0]        req_shift,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ_A = 2'd1;
  localparam logic [1:0] S_READ_B = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] rn;
    logic [ADDR_W-1:0] rm;
    logic [1:0]        shift;
  } req_t;

  logic [NREGS-1:0][DATA_W-1:0] rf_q, rf_d;
  logic [1:0]        state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        shift_q, shift_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = rst_n && (state_q == S_IDLE);
  assign out_valid = vld_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;

  always_comb begin
    rf_d = rf_q;
    for (int i = 0; i < NREGS; i++)
      if (wb_en && wb_addr == ADDR_W'(i)) rf_d[i] = wb_data;
  end

  // Same-edge writeback to the register being read wins over the stale array value.
  always_comb begin
    rd_idx  = (state_q == S_READ_A) ? req_q.rn : req_q.rm;
    rd_data = (wb_en && wb_addr == rd_idx) ? wb_data : rf_q[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    a_d     = a_q;
    b_d     = b_q;
    shift_d = shift_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        req_d.rn    = req_rn;
        req_d.rm    = req_rm;
        req_d.shift = req_shift;
        state_d     = S_READ_A;
      end
      S_READ_A: begin
        a_d     = rd_data;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        b_d     = rd_data;
        shift_d = req_q.shift;
        vld_d   = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (out_ready) begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q    <= '0;
      state_q <= S_IDLE;
      req_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      rf_q    <= rf_d;
      state_q <= state_d;
      req_q   <= req_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios, a vector table and a
// randomized run against a timestamp-based transaction model.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_rn = '0, req_rm = '0;
  logic [1:0]  req_shift = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;

  int total = 0;
  int passed = 0;

  operand_fetch_stage #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_shift(req_shift),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;
  vec_t tbl[5];

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] regv(input int i);
    return 16'hA000 + 16'(i) * 16'h0111;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
    tick();
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_ready", req_ready, 1'b0);
    chk16("rst_a", a_out, 16'h0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [2:0] ad, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = ad; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    chk1("issue_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_rn = rn; req_rm = rm; req_shift = sh;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Transaction-level reference: timestamps of accept, register snapshot after each edge.
  logic [15:0] mrf[8];
  bit          outst;
  int          t_acc, e;
  logic [2:0]  m_rn, m_rm;
  logic [1:0]  m_sh, es;
  logic [15:0] ea, eb;

  initial begin
    int acc[$];
    logic [15:0] got[$];
    logic [15:0] expq[$];
    int k;
    bit ready_now;

    tbl[0] = '{3'd0, 3'd7, 2'd0, 16'hA000, 16'hA777};
    tbl[1] = '{3'd3, 3'd5, 2'd3, 16'hA333, 16'hA555};
    tbl[2] = '{3'd7, 3'd0, 2'd1, 16'hA777, 16'hA000};
    tbl[3] = '{3'd6, 3'd6, 2'd2, 16'hA666, 16'hA666};
    tbl[4] = '{3'd1, 3'd4, 2'd3, 16'hA111, 16'hA444};

    do_reset();
    chk1("idle_ready", req_ready, 1'b1);

    // basic fetch, two cycles after accept
    wr(3'd3, 16'h00F0);
    wr(3'd5, 16'h8001);
    issue(3'd3, 3'd5, 2'b11);
    tick();
    chk1("s1_not_yet", out_valid, 1'b0);
    tick();
    chk1("s1_valid", out_valid, 1'b1);
    chk16("s1_a", a_out, 16'h00F0);
    chk16("s1_b", b_out, 16'h8001);
    chk16("s1_sh", 16'(shift_out), 16'd3);

    // stall with out_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("s2_valid", out_valid, 1'b1);
      chk1("s2_ready", req_ready, 1'b0);
      chk16("s2_a", a_out, 16'h00F0);
      chk16("s2_b", b_out, 16'h8001);
      chk16("s2_sh", 16'(shift_out), 16'd3);
    end
    consume();
    chk1("s2_drop", out_valid, 1'b0);
    chk1("s2_ready1", req_ready, 1'b1);

    // bypass in READ_B, ignored in HOLD
    issue(3'd3, 3'd5, 2'b01);
    tick();
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
    tick();
    wb_en = 1'b0;
    chk1("s3_valid", out_valid, 1'b1);
    chk16("s3_a", a_out, 16'h00F0);
    chk16("s3_byp", b_out, 16'h1234);
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555;
    tick();
    wb_en = 1'b0;
    chk16("s3_hold", b_out, 16'h1234);
    consume();

    // rn == rm
    wr(3'd2, 16'hBEEF);
    issue(3'd2, 3'd2, 2'b00);
    tick(); tick();
    chk16("s4_a", a_out, 16'hBEEF);
    chk16("s4_b", b_out, 16'hBEEF);
    consume();

    // async reset while in READ_B
    issue(3'd3, 3'd5, 2'b10);
    tick();
    chk16("s5_pre_a", a_out, 16'h00F0);
    rst_n = 1'b0;
    #1;
    chk1("s5_valid", out_valid, 1'b0);
    chk1("s5_ready", req_ready, 1'b0);
    chk16("s5_a", a_out, 16'h0);
    chk16("s5_b", b_out, 16'h0);
    chk16("s5_sh", 16'(shift_out), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    issue(3'd3, 3'd5, 2'b00);
    tick(); tick();
    chk16("s5_r3", a_out, 16'h0);
    chk16("s5_r5", b_out, 16'h0);
    consume();

    // vector table against a known preload
    for (int i = 0; i < 8; i++) wr(3'(i), regv(i));
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      issue(tbl[i].rn, tbl[i].rm, tbl[i].sh);
      while (!out_valid && n < 10) begin tick(); n++; end
      chk1("tbl_valid", out_valid, 1'b1);
      chk16("tbl_a", a_out, tbl[i].ea);
      chk16("tbl_b", b_out, tbl[i].eb);
      chk16("tbl_sh", 16'(shift_out), 16'(tbl[i].sh));
      consume();
    end

    // back-to-back with out_ready tied high
    out_ready = 1'b1; req_valid = 1'b1; k = 0;
    for (int t = 0; t < 26; t++) begin
      if (out_valid) got.push_back(a_out);
      req_rn = 3'(k); req_rm = 3'(7 - k); req_shift = 2'(k);
      if (req_ready) begin acc.push_back(t); expq.push_back(regv(k)); k++; end
      tick();
    end
    req_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (out_valid) got.push_back(a_out);
      tick();
    end
    out_ready = 1'b0;
    chk16("b2b_accepts", 16'(acc.size()), 16'd7);
    for (int j = 1; j < acc.size(); j++)
      chk16("b2b_spacing", 16'(acc[j] - acc[j-1]), 16'd4);
    chk16("b2b_outputs", 16'(got.size()), 16'(acc.size()));
    for (int j = 0; j < got.size() && j < expq.size(); j++)
      chk16("b2b_order", got[j], expq[j]);

    // randomized run against the transaction model
    do_reset();
    for (int i = 0; i < 8; i++) mrf[i] = '0;
    outst = 1'b0; t_acc = 0; e = 0; ea = '0; eb = '0; es = '0;
    m_rn = '0; m_rm = '0; m_sh = '0;
    for (int i = 0; i < 500; i++) begin
      chk1("rnd_ready", req_ready, !outst);
      chk1("rnd_valid", out_valid, outst && (e - 1 >= t_acc + 2));
      chk16("rnd_a", a_out, ea);
      chk16("rnd_b", b_out, eb);
      chk16("rnd_sh", 16'(shift_out), 16'(es));
      req_valid = 1'($urandom);
      req_rn    = 3'($urandom);
      req_rm    = 3'($urandom);
      req_shift = 2'($urandom);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_addr   = 3'($urandom);
      wb_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      ready_now = !outst;
      if (outst && e >= t_acc + 3 && out_ready) outst = 1'b0;
      else if (ready_now && req_valid) begin
        outst = 1'b1; t_acc = e; m_rn = req_rn; m_rm = req_rm; m_sh = req_shift;
      end
      if (wb_en) mrf[wb_addr] = wb_data;
      if (outst && e == t_acc + 1) ea = mrf[m_rn];
      if (outst && e == t_acc + 2) begin eb = mrf[m_rm]; es = m_sh; end
      e++;
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
